// File: rtl/params_pkg.sv
// Shared definitions for the RSNN parameter load/readback control units:
// bank geometry defaults and the control-unit state encoding.
package params_pkg;

  localparam int NUM_PARAMS_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SNAP = 2'b01,
    ST_SEND = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a level request; the history register only
// advances while enable is high, so a frozen block does not lose an edge.
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic in,
  output logic pulse
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev <= 1'b0;
    end else if (enable) begin
      r_prev <= in;
    end
  end

  assign pulse = in & ~r_prev;

endmodule

// File: rtl/params_readback_cu.sv
// Reads the parameter bank back to the host: atomic snapshot (deferred while
// the loader is writing), then one byte per valid/ready handshake in address order.
module params_readback_cu
  import params_pkg::*;
#(
  parameter int NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             read_params,
  input  logic                             params_reg_enable,
  input  logic [NUM_PARAMS*DATA_WIDTH-1:0] params_flat,
  input  logic                             data_ready,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  output logic [ADDR_WIDTH-1:0]            param_addr,
  output logic                             busy,
  output logic                             read_done,
  output logic [1:0]                       dbg_state
);

  // Handshake: a byte moves on a rising clk edge where data_valid and
  // data_ready are both high; while data_ready is low the byte and its
  // address are held unchanged.

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PARAMS - 1);

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [ADDR_WIDTH-1:0]            r_index;
  logic [ADDR_WIDTH-1:0]            w_index_nxt;
  logic [NUM_PARAMS*DATA_WIDTH-1:0] r_shadow;
  logic [NUM_PARAMS*DATA_WIDTH-1:0] w_shadow_nxt;
  logic                             w_req_edge;

  rise_edge_det u_req_edge (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .in     (read_params),
    .pulse  (w_req_edge)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_index  <= '0;
      r_shadow <= '0;
    end else if (enable) begin
      r_state  <= w_state_nxt;
      r_index  <= w_index_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_shadow_nxt = r_shadow;
    case (r_state)
      ST_IDLE: begin
        if (w_req_edge) begin
          w_state_nxt = ST_SNAP;
          w_index_nxt = '0;
        end
      end
      ST_SNAP: begin
        // An in-flight write wins; snapshot only once the bank is quiet.
        if (!params_reg_enable) begin
          w_shadow_nxt = params_flat;
          w_state_nxt  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (data_ready) begin
          if (r_index == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_index_nxt = r_index + 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_index_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    data_out   = '0;
    data_valid = 1'b0;
    if (r_state == ST_SEND) begin
      data_out   = r_shadow[r_index*DATA_WIDTH +: DATA_WIDTH];
      data_valid = enable;
    end
  end

  assign param_addr = r_index;
  assign busy       = (r_state != ST_IDLE);
  assign read_done  = (r_state == ST_DONE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_params_readback_cu.sv
// Directed bench for params_readback_cu: expected bytes are queued when a
// readback is requested and checked as each handshake completes.
module tb_params_readback_cu;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        read_params;
  logic        params_reg_enable;
  logic [31:0] params_flat;
  logic        data_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [1:0]  param_addr;
  logic        busy;
  logic        read_done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  logic [7:0] exp_q[$];
  logic [1:0] addr_q[$];

  logic       stalled = 1'b0;
  logic [7:0] hold_byte;
  logic [1:0] hold_addr;

  params_readback_cu dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .read_params       (read_params),
    .params_reg_enable (params_reg_enable),
    .params_flat       (params_flat),
    .data_ready        (data_ready),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .param_addr        (param_addr),
    .busy              (busy),
    .read_done         (read_done),
    .dbg_state         (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bank(input logic [31:0] bank);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bank[i*8 +: 8]);
      addr_q.push_back(2'(i));
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      nxt();
      @(negedge clk);
      if (read_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_data_out"},   32'(data_out),   32'h0);
    chk({tag, "_data_valid"}, 32'(data_valid), 32'h0);
    chk({tag, "_param_addr"}, 32'(param_addr), 32'h0);
    chk({tag, "_busy"},       32'(busy),       32'h0);
    chk({tag, "_read_done"},  32'(read_done),  32'h0);
  endtask

  // scoreboard: pop on every handshake, and check stalled bytes are held
  always @(negedge clk) begin
    if (!rst) begin
      stalled = 1'b0;
    end else if (data_valid) begin
      if (stalled) begin
        chk("hold_data", 32'(data_out), 32'(hold_byte));
        chk("hold_addr", 32'(param_addr), 32'(hold_addr));
      end
      if (data_ready) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_byte: observed %0h expected none", data_out);
        end
        if (exp_q.size() != 0) begin
          chk("stream_data", 32'(data_out), 32'(exp_q.pop_front()));
          chk("stream_addr", 32'(param_addr), 32'(addr_q.pop_front()));
        end
        n_xfer++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        hold_byte = data_out;
        hold_addr = param_addr;
      end
    end
  end

  initial begin
    logic [31:0] bank;
    logic [3:0]  pat;
    int          n_snap;
    int          n_rd;
    logic        seen;

    rst = 1'b0; enable = 1'b1; read_params = 1'b0; params_reg_enable = 1'b0;
    params_flat = 32'hDDCC_BBAA; data_ready = 1'b1;
    pat = 4'b1001;

    // reset
    repeat (2) nxt();
    @(negedge clk);
    chk_idle_outputs("reset");
    nxt(); rst = 1'b1;
    repeat (3) nxt();
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'h0);

    // basic readback, data_ready tied high, request held high afterwards
    nxt(); read_params = 1'b1; push_bank(32'hDDCC_BBAA);
    @(negedge clk); chk("t1_idle_before_edge", 32'(busy), 32'h0);
    nxt(); @(negedge clk);
    chk("t1_snap_state", 32'(dbg_state), 32'h1);
    chk("t1_snap_no_valid", 32'(data_valid), 32'h0);
    nxt(); @(negedge clk);
    chk("t1_latency_valid", 32'(data_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      nxt(); @(negedge clk);
      chk("t1_no_early_done", 32'(read_done), 32'h0);
    end
    nxt(); @(negedge clk);
    chk("t1_read_done", 32'(read_done), 32'h1);
    chk("t1_busy_in_done", 32'(busy), 32'h1);
    nxt(); @(negedge clk);
    chk("t1_done_one_cycle", 32'(read_done), 32'h0);
    chk("t1_busy_fell", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      nxt(); @(negedge clk);
      chk("t1_no_retrigger", 32'(busy), 32'h0);
    end
    chk("t1_queue_empty", 32'(exp_q.size()), 32'h0);
    nxt(); read_params = 1'b0;

    // write in progress across the request edge; bank changes during the write
    nxt(); params_reg_enable = 1'b1; read_params = 1'b1; push_bank(32'h4433_2211);
    n_snap = 0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (i == 0) params_flat = 32'h4433_2211;
      if (i == 2) params_reg_enable = 1'b0;
      @(negedge clk);
      if (dbg_state == 2'b01) n_snap++;
    end
    chk("t2_snap_cycles", 32'(n_snap), 32'd3);
    nxt(); @(negedge clk);
    chk("t2_send_state", 32'(dbg_state), 32'h2);
    params_reg_enable = 1'b1; params_flat = 32'h9999_9999;
    wait_done("t2_done_seen", 20);
    params_reg_enable = 1'b0; read_params = 1'b0;
    chk("t2_queue_empty", 32'(exp_q.size()), 32'h0);

    // back-pressure with data_ready pattern 1,0,0,1,...
    nxt();
    bank = $urandom_range(32'hFFFF_FFFF, 0);
    params_flat = bank; read_params = 1'b1; push_bank(bank); n_xfer = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nxt();
      data_ready = pat[i % 4];
      if (i == 2) read_params = 1'b0;
      @(negedge clk);
      if (read_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t3_done_seen", 32'(seen), 32'h1);
    chk("t3_transfers", 32'(n_xfer), 32'd4);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'h0);
    data_ready = 1'b1;

    // enable dropped for two cycles while byte 1 is presented
    nxt(); params_flat = 32'hDDCC_BBAA; read_params = 1'b1; push_bank(32'hDDCC_BBAA);
    n_xfer = 0;
    nxt(); nxt(); @(negedge clk);
    chk("t4_first_addr", 32'(param_addr), 32'h0);
    nxt(); enable = 1'b0; @(negedge clk);
    chk("t4_frozen_valid", 32'(data_valid), 32'h0);
    chk("t4_frozen_addr", 32'(param_addr), 32'h1);
    nxt(); @(negedge clk);
    chk("t4_frozen_valid2", 32'(data_valid), 32'h0);
    chk("t4_frozen_addr2", 32'(param_addr), 32'h1);
    chk("t4_frozen_busy", 32'(busy), 32'h1);
    nxt(); enable = 1'b1; read_params = 1'b0; @(negedge clk);
    chk("t4_resume_valid", 32'(data_valid), 32'h1);
    chk("t4_resume_byte", 32'(data_out), 32'hBB);
    wait_done("t4_done_seen", 10);
    chk("t4_transfers", 32'(n_xfer), 32'd4);

    // reset in the middle of SEND
    nxt(); read_params = 1'b1; push_bank(32'hDDCC_BBAA);
    nxt(); nxt(); nxt(); @(negedge clk);
    chk("t5_mid_addr", 32'(param_addr), 32'h1);
    nxt(); rst = 1'b0; read_params = 1'b0;
    exp_q.delete(); addr_q.delete();
    nxt(); @(negedge clk);
    chk_idle_outputs("t5_abort");
    nxt(); rst = 1'b1;
    n_rd = 0;
    for (int i = 0; i < 6; i++) begin
      nxt(); @(negedge clk);
      if (read_done) n_rd++;
    end
    chk("t5_no_read_done", 32'(n_rd), 32'h0);
    chk("t5_idle_busy", 32'(busy), 32'h0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
